kernel_sysid_checker: RTL and testbench
=======================================

KERNEL_SYSID_CHECKER -- requirements
Module: kernel_sysid_checker

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- EXPECTED_ID, 32'd1483930777, system ID value required at slave word 0.
- CHECK_TS, 0, when 1 the timestamp at word 1 must also equal EXPECTED_TS.
- EXPECTED_TS, 32'd0, required timestamp value; used only when CHECK_TS=1.
- TIMEOUT, 1023, maximum cycles allowed per read; legal range 2..65535, 16-bit counter.
- AUTO_START, 1, when 1 the check starts without a start pulse after reset release.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clock, in, 1, single clock domain; all logic on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a check; sampled only in IDLE or DONE.
- avm_address, out, 1, Avalon-MM word address: 0 = ID, 1 = timestamp.
- avm_read, out, 1, Avalon-MM read request.
- avm_waitrequest, in, 1, slave stall; request accepted on a cycle with avm_read=1 and waitrequest=0.
- avm_readdata, in, 32, read data; valid only with avm_readdatavalid.
- avm_readdatavalid, in, 1, read response strobe.
- id_value, out, 32, captured ID word.
- ts_value, out, 32, captured timestamp word.
- busy, out, 1, high in any state except IDLE and DONE.
- done, out, 1, level; high in DONE.
- id_match, out, 1, result; meaningful only when done=1.
- timeout, out, 1, set when a read exceeds TIMEOUT cycles.

Function
REQ-003 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and DONE.
REQ-004 The FSM SHALL move IDLE -> ID_REQ on start=1, or on the first clock after reset release when AUTO_START=1.
REQ-005 In ID_REQ the block SHALL drive avm_read=1 and avm_address=0, and SHALL hold both stable until acceptance, then go to ID_WAIT.
REQ-006 In ID_WAIT the block SHALL drive avm_read=0; on avm_readdatavalid=1 it SHALL capture avm_readdata into id_value and go to TS_REQ.
REQ-007 TS_REQ and TS_WAIT SHALL behave as ID_REQ and ID_WAIT, with avm_address=1 and capture into ts_value, then go to DONE.
REQ-008 The block SHALL keep at most one read outstanding.
REQ-009 avm_readdatavalid SHALL be ignored in any state other than ID_WAIT and TS_WAIT.
REQ-010 A response SHALL NOT be accepted in the same cycle as its request acceptance; the earliest accepted response is in the next cycle.
REQ-011 On entering DONE, id_match SHALL be set to (id_value==EXPECTED_ID) && (CHECK_TS==0 || ts_value==EXPECTED_TS), using the captured values and including the word captured on the transition cycle.
REQ-012 On entering DONE, done SHALL be set to 1.
REQ-013 A 16-bit timeout counter SHALL clear on every transition into ID_REQ or TS_REQ.
REQ-014 The timeout counter SHALL increment on every cycle spent in a REQ or WAIT state.
REQ-015 When the timeout counter equals TIMEOUT-1 and the current phase has not completed that cycle, the FSM SHALL go to DONE with timeout=1, id_match=0 and avm_read=0 on the next cycle.
REQ-016 Completion SHALL win over timeout when both occur in the same cycle.
REQ-017 When start=1 in DONE, the block SHALL clear done, id_match and timeout, SHALL retain id_value and ts_value until overwritten, and SHALL go to ID_REQ.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 outputs SHALL be registered except avm_read, avm_address and busy, which decode the state register directly.

Reset
REQ-020 While reset_n=0 the state SHALL be IDLE.
REQ-021 While reset_n=0, avm_read, avm_address, busy, done, id_match and timeout SHALL be 0, and id_value and ts_value SHALL be 32'h0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately.
REQ-023 A response arriving after reset release SHALL be ignored, because the block is in IDLE or ID_REQ at that point.

Verification
REQ-024 Zero-wait slave: AUTO_START=1, waitrequest=0, readdatavalid one cycle after acceptance, ID=1483930777, TS=0 -> done=1 with id_match=1 on cycle 5 after reset release, id_value=32'd1483930777.
REQ-025 Stalled slave: waitrequest=1 for 3 cycles in ID_REQ -> avm_read=1 and avm_address=0 held stable for 4 cycles, exactly one request accepted, result unchanged.
REQ-026 ID mismatch: slave returns 32'h12345678 at word 0 -> done=1, id_match=0, timeout=0, id_value=32'h12345678.
REQ-027 Timeout: TIMEOUT=16, readdatavalid never asserted -> done=1 and timeout=1 exactly 16 cycles after ID_REQ entry, avm_read=0 from then on.
REQ-028 CHECK_TS=1, EXPECTED_TS=32'h4C000000, slave TS=32'h4C000001 -> id_match=0; rerun via start with the correct TS -> id_match=1 and timeout=0.
REQ-029 Stray strobe and reset: readdatavalid pulsed in ID_REQ is ignored; reset_n pulsed low during TS_WAIT -> all outputs 0 and a fresh check starts when AUTO_START=1.

Source files
------------

// File: rtl/kernel_sysid_checker.sv
// Boot-time system ID checker: reads the sysid slave's ID word and timestamp word
// over Avalon-MM and reports whether they match the expected build.
module kernel_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd1483930777,
    parameter bit          CHECK_TS    = 1'b0,
    parameter logic [31:0] EXPECTED_TS = 32'd0,
    parameter int          TIMEOUT     = 1023,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic [15:0] r_cnt;
    logic [31:0] r_id;
    logic [31:0] r_ts;
    logic        r_done;
    logic        r_match;
    logic        r_tmo;
    logic        w_in_phase;
    logic        w_tmo_hit;
    logic        w_fin_ok;
    logic        w_fin_tmo;
    logic        w_clr_cnt;

    assign w_in_phase = (r_state == S_ID_REQ) || (r_state == S_ID_WAIT) ||
                        (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);
    assign w_tmo_hit  = w_in_phase && (r_cnt == TMO_LAST);
    // The counter restarts whenever a new read phase begins
    assign w_clr_cnt  = ((w_next == S_ID_REQ) && (r_state != S_ID_REQ)) ||
                        ((w_next == S_TS_REQ) && (r_state != S_TS_REQ));

    always_comb begin
        w_next    = r_state;
        w_fin_ok  = 1'b0;
        w_fin_tmo = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start || r_armed) w_next = S_ID_REQ;
            end
            S_ID_REQ: begin
                if (w_tmo_hit)             w_fin_tmo = 1'b1;
                else if (!avm_waitrequest) w_next = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (avm_readdatavalid) w_next = S_TS_REQ;
                else if (w_tmo_hit)    w_fin_tmo = 1'b1;
            end
            S_TS_REQ: begin
                if (w_tmo_hit)             w_fin_tmo = 1'b1;
                else if (!avm_waitrequest) w_next = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    w_next   = S_DONE;
                    w_fin_ok = 1'b1;
                end else if (w_tmo_hit) begin
                    w_fin_tmo = 1'b1;
                end
            end
            S_DONE: begin
                if (start) w_next = S_ID_REQ;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_fin_tmo) w_next = S_DONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= AUTO_START;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b0;
            if (w_clr_cnt)       r_cnt <= '0;
            else if (w_in_phase) r_cnt <= r_cnt + 16'd1;
        end
    end

    // The TS word is compared straight off the bus on the cycle it is captured
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id    <= '0;
            r_ts    <= '0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            if ((r_state == S_ID_WAIT) && avm_readdatavalid) r_id <= avm_readdata;
            if ((r_state == S_TS_WAIT) && avm_readdatavalid) r_ts <= avm_readdata;
            if ((r_state == S_DONE) && start) begin
                r_done  <= 1'b0;
                r_match <= 1'b0;
                r_tmo   <= 1'b0;
            end else if (w_fin_ok) begin
                r_done  <= 1'b1;
                r_match <= (r_id == EXPECTED_ID) && (!CHECK_TS || (avm_readdata == EXPECTED_TS));
            end else if (w_fin_tmo) begin
                r_done  <= 1'b1;
                r_match <= 1'b0;
                r_tmo   <= 1'b1;
            end
        end
    end

    assign avm_read    = (r_state == S_ID_REQ) || (r_state == S_TS_REQ);
    assign avm_address = (r_state == S_TS_REQ);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign id_value    = r_id;
    assign ts_value    = r_ts;
    assign done        = r_done;
    assign id_match    = r_match;
    assign timeout     = r_tmo;
endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: two instances (default and TS-checking/short-timeout)
// behind a configurable Avalon-MM slave, checked against a phase-timing model.
module tb_kernel_sysid_checker;
    localparam logic [31:0] EXP_ID  = 32'd1483930777;
    localparam logic [31:0] EXP_TS1 = 32'h4C000000;
    localparam int          TMO0    = 1023;
    localparam int          TMO1    = 16;

    logic        clock;
    logic        reset_n;
    logic [1:0]  start_s, addr_s, read_s, wreq, rdv_r, rdv_w, stray, busy_s, done_s, match_s, tmo_s;
    logic [31:0] rdata_r [2];
    logic [31:0] rdata_w [2];
    logic [31:0] id_s [2];
    logic [31:0] ts_s [2];

    int          stall_n [2][2];
    int          lat_n [2][2];
    logic [31:0] word_id [2];
    logic [31:0] word_ts [2];
    bit   [1:0]  mute;
    int          st_cnt [2];
    int          cd [2];
    logic [1:0]  paddr;
    int          rd0_cyc;
    int          acc0;
    logic [31:0] m_id [2];
    logic [31:0] m_ts [2];
    int          n_total;
    int          n_bad;

    kernel_sysid_checker u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start_s[0]),
        .avm_address(addr_s[0]), .avm_read(read_s[0]), .avm_waitrequest(wreq[0]),
        .avm_readdata(rdata_w[0]), .avm_readdatavalid(rdv_w[0]),
        .id_value(id_s[0]), .ts_value(ts_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .id_match(match_s[0]), .timeout(tmo_s[0])
    );

    kernel_sysid_checker #(
        .CHECK_TS(1'b1), .EXPECTED_TS(EXP_TS1), .TIMEOUT(TMO1), .AUTO_START(1'b0)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start_s[1]),
        .avm_address(addr_s[1]), .avm_read(read_s[1]), .avm_waitrequest(wreq[1]),
        .avm_readdata(rdata_w[1]), .avm_readdatavalid(rdv_w[1]),
        .id_value(id_s[1]), .ts_value(ts_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .id_match(match_s[1]), .timeout(tmo_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: stalls each request stall_n cycles, answers lat_n cycles after acceptance.
    // It is deliberately not reset by reset_n so in-flight answers survive a DUT reset.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wreq[i]    = read_s[i] && (st_cnt[i] < stall_n[i][addr_s[i]]);
            rdv_w[i]   = rdv_r[i] | stray[i];
            rdata_w[i] = stray[i] ? 32'hDEADBEEF : rdata_r[i];
        end
    end

    initial begin
        rdv_r = '0; paddr = '0; rd0_cyc = 0; acc0 = 0;
        for (int i = 0; i < 2; i++) begin st_cnt[i] = 0; cd[i] = 0; rdata_r[i] = '0; end
    end

    always @(posedge clock) begin
        if (read_s[0] && !addr_s[0]) rd0_cyc <= rd0_cyc + 1;
        if (read_s[0] && !addr_s[0] && !wreq[0]) acc0 <= acc0 + 1;
        for (int i = 0; i < 2; i++) begin
            rdv_r[i] <= 1'b0;
            if (read_s[i] && !wreq[i]) begin
                st_cnt[i] <= 0;
                paddr[i]  <= addr_s[i];
                if (mute[i]) begin
                    cd[i] <= 0;
                end else if (lat_n[i][addr_s[i]] <= 1) begin
                    cd[i]      <= 0;
                    rdv_r[i]   <= 1'b1;
                    rdata_r[i] <= addr_s[i] ? word_ts[i] : word_id[i];
                end else begin
                    cd[i] <= lat_n[i][addr_s[i]] - 1;
                end
            end else begin
                st_cnt[i] <= read_s[i] ? st_cnt[i] + 1 : 0;
                if (cd[i] > 0) begin
                    cd[i] <= cd[i] - 1;
                    if (cd[i] == 1) begin
                        rdv_r[i]   <= 1'b1;
                        rdata_r[i] <= paddr[i] ? word_ts[i] : word_id[i];
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_slave(input int i, input int s_id, input int l_id, input int s_ts,
                             input int l_ts, input logic [31:0] wid, input logic [31:0] wts);
        stall_n[i][0] = s_id; lat_n[i][0] = l_id;
        stall_n[i][1] = s_ts; lat_n[i][1] = l_ts;
        word_id[i] = wid; word_ts[i] = wts;
    endtask

    // A phase lasts stall+1+latency cycles; it completes if that fits in the limit,
    // otherwise the check ends exactly `limit` cycles after the phase started.
    function automatic void predict(input int i, output int cyc, output bit tmo, output bit mt,
                                    output logic [31:0] idv, output logic [31:0] tsv);
        int lim  = (i == 0) ? TMO0 : TMO1;
        int t_id = stall_n[i][0] + 1 + lat_n[i][0];
        int t_ts = stall_n[i][1] + 1 + lat_n[i][1];
        idv = m_id[i]; tsv = m_ts[i]; tmo = 1'b0; mt = 1'b0;
        if (mute[i] || t_id > lim) begin
            cyc = 1 + lim; tmo = 1'b1;
        end else begin
            idv = word_id[i];
            if (t_ts > lim) begin
                cyc = 1 + t_id + lim; tmo = 1'b1;
            end else begin
                cyc = 1 + t_id + t_ts;
                tsv = word_ts[i];
                mt  = (idv == EXP_ID) && ((i == 0) || (tsv == EXP_TS1));
            end
        end
    endfunction

    task automatic check_zero(input int i, input string tag);
        check_val({tag, " read"}, read_s[i], 0);
        check_val({tag, " addr"}, addr_s[i], 0);
        check_val({tag, " busy"}, busy_s[i], 0);
        check_val({tag, " done"}, done_s[i], 0);
        check_val({tag, " match"}, match_s[i], 0);
        check_val({tag, " tmo"}, tmo_s[i], 0);
        check_val({tag, " id"}, id_s[i], 0);
        check_val({tag, " ts"}, ts_s[i], 0);
    endtask

    // Entered and left on a negedge; counts rising edges until done is seen.
    task automatic run_chk(input int i, input bit use_start, input int start_at,
                           input int stray_at, input string tag);
        int cyc; bit e_tmo; bit e_mt; logic [31:0] e_id; logic [31:0] e_ts; int n;
        predict(i, cyc, e_tmo, e_mt, e_id, e_ts);
        if (use_start) start_s[i] = 1'b1;
        n = 0;
        while (n < 2100) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            start_s[i] = (n == start_at);
            stray[i]   = (n == stray_at);
            if (done_s[i]) break;
        end
        start_s[i] = 1'b0;
        stray[i]   = 1'b0;
        check_val({tag, " cycles"}, n, cyc);
        check_val({tag, " done"}, done_s[i], 1);
        check_val({tag, " match"}, match_s[i], e_mt);
        check_val({tag, " timeout"}, tmo_s[i], e_tmo);
        check_val({tag, " id"}, id_s[i], e_id);
        check_val({tag, " ts"}, ts_s[i], e_ts);
        check_val({tag, " busy"}, busy_s[i], 0);
        check_val({tag, " read"}, read_s[i], 0);
        m_id[i] = e_id;
        m_ts[i] = e_ts;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0; int a0;
        n_total = 0; n_bad = 0;
        reset_n = 1'b0; start_s = '0; stray = '0; mute = '0;
        for (int i = 0; i < 2; i++) begin m_id[i] = '0; m_ts[i] = '0; end
        set_slave(0, 0, 1, 0, 1, EXP_ID, 32'h0);
        set_slave(1, 0, 1, 0, 1, EXP_ID, EXP_TS1);
        repeat (3) @(negedge clock);
        check_zero(0, "reset0");
        check_zero(1, "reset1");

        reset_n = 1'b1;
        run_chk(0, 1'b0, -1, -1, "zero_wait");
        check_val("no_auto busy1", busy_s[1], 0);
        repeat (10) @(negedge clock);

        set_slave(0, 3, 1, 0, 1, EXP_ID, 32'h0);
        r0 = rd0_cyc; a0 = acc0;
        run_chk(0, 1'b1, -1, 1, "stall_stray");
        check_val("stall read cycles", rd0_cyc - r0, 4);
        check_val("stall accepts", acc0 - a0, 1);
        repeat (10) @(negedge clock);

        set_slave(0, 0, 1, 0, 1, 32'h12345678, 32'h0);
        run_chk(0, 1'b1, -1, -1, "id_mismatch");
        repeat (10) @(negedge clock);

        mute[1] = 1'b1;
        run_chk(1, 1'b1, -1, -1, "timeout16");
        mute[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_val("post_tmo read", read_s[1], 0);
        end
        repeat (20) @(negedge clock);

        set_slave(1, 0, 1, 0, 1, EXP_ID, 32'h4C000001);
        run_chk(1, 1'b1, -1, -1, "ts_wrong");
        repeat (10) @(negedge clock);
        set_slave(1, 1, 2, 2, 1, EXP_ID, EXP_TS1);
        run_chk(1, 1'b1, -1, -1, "ts_right");
        repeat (10) @(negedge clock);

        set_slave(1, 7, 8, 0, 1, EXP_ID, EXP_TS1);
        run_chk(1, 1'b1, -1, -1, "id_phase16");
        repeat (20) @(negedge clock);
        set_slave(1, 8, 8, 0, 1, EXP_ID, EXP_TS1);
        run_chk(1, 1'b1, -1, -1, "id_phase17");
        repeat (20) @(negedge clock);
        set_slave(1, 0, 1, 0, 16, EXP_ID, EXP_TS1);
        run_chk(1, 1'b1, -1, -1, "ts_phase17");
        repeat (20) @(negedge clock);

        // Abort during TS_WAIT; the stale TS answer lands while the restart sits in ID_REQ
        set_slave(0, 0, 1, 0, 5, EXP_ID, 32'h0BAD0001);
        start_s[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_s[0] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("ts_wait busy", busy_s[0], 1);
        check_val("ts_wait read", read_s[0], 0);
        check_val("ts_wait id", id_s[0], EXP_ID);
        reset_n = 1'b0;
        #1;
        check_zero(0, "mid_reset");
        for (int i = 0; i < 2; i++) begin m_id[i] = '0; m_ts[i] = '0; end
        set_slave(0, 3, 1, 0, 1, EXP_ID, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        run_chk(0, 1'b0, -1, -1, "after_reset");
        repeat (10) @(negedge clock);

        for (int k = 0; k < 24; k++) begin
            int i;
            int smax;
            i = k % 2;
            smax = (i == 0) ? 5 : 9;
            set_slave(i, $urandom_range(0, smax), $urandom_range(1, smax),
                      $urandom_range(0, smax), $urandom_range(1, smax),
                      ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom(),
                      ($urandom_range(0, 1) == 1) ? EXP_TS1 : $urandom());
            mute[i] = (i == 1) && ($urandom_range(0, 5) == 0);
            run_chk(i, 1'b1, ($urandom_range(0, 1) == 1) ? 2 : -1, -1, "random");
            mute[i] = 1'b0;
            repeat (25) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
